// File: rtl/i2c_reg_config.sv
// Camera register-init sequencer: after the power-up delay, walks the OV9281 init table and hands
// one {dev, reg_hi, reg_lo, data} word per transfer to the i2c write engine, retrying on NACK.
module i2c_reg_config #(
  parameter int         PWR_DELAY  = 4000,
  parameter int         GAP_CYCLES = 4,
  parameter int         MAX_RETRY  = 3,
  parameter int         REG_NUM    = 64,
  parameter logic [7:0] DEV_ADDR   = 8'hC0,
  parameter int         DELAY_UNIT = 20
) (
  input  logic        clock_i2c,
  input  logic        camera_rstn,
  input  logic        cfg_restart,
  input  logic        tr_end,
  input  logic        ack,
  output logic        start,
  output logic [31:0] i2c_data,
  output logic [7:0]  reg_index,
  output logic        cfg_done,
  output logic        cfg_err
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  // state    | meaning
  // PWR_WAIT | sensor power-up settle time
  // LOAD     | fetch table[reg_index] into i2c_data
  // SEND     | start high, waiting for the engine's tr_end
  // CHECK    | judge ack, pick advance / retry / error
  // GAP      | start low so the engine drops tr_end and rewinds
  // ADV      | step to next entry or finish
  // DELAY    | timed wait entry, no bus traffic
  // DONE     | table complete; ERROR: entry ran out of retries
  typedef enum logic [3:0] {
    PWR_WAIT, LOAD, SEND, CHECK, GAP, ADV, DELAY, DONE, ERROR
  } state_t;

  state_t          state, state_n;
  logic [15:0]     cnt, cnt_n;
  logic [RW-1:0]   retry, retry_n;
  logic [7:0]      index_n;
  logic [31:0]     data_n;
  logic            done_n, err_n, start_n;
  logic [24:0]     entry;
  logic [15:0]     delay_len;

  function automatic logic [24:0] table_lookup(input logic [7:0] idx);
    case (idx)
      8'd0:  return {1'b0, 16'h0103, 8'h01};
      8'd1:  return {1'b1, 16'h0000, 8'd10};
      8'd2:  return {1'b0, 16'h0302, 8'h32};
      8'd3:  return {1'b0, 16'h030d, 8'h50};
      8'd4:  return {1'b0, 16'h030e, 8'h02};
      8'd5:  return {1'b0, 16'h3001, 8'h00};
      8'd6:  return {1'b0, 16'h3004, 8'h00};
      8'd7:  return {1'b0, 16'h3005, 8'h00};
      8'd8:  return {1'b0, 16'h3006, 8'h04};
      8'd9:  return {1'b0, 16'h3011, 8'h0a};
      8'd10: return {1'b0, 16'h3013, 8'h18};
      8'd11: return {1'b0, 16'h301c, 8'hf0};
      8'd12: return {1'b0, 16'h3022, 8'h01};
      8'd13: return {1'b0, 16'h3030, 8'h10};
      8'd14: return {1'b0, 16'h3039, 8'h32};
      8'd15: return {1'b0, 16'h303a, 8'h00};
      8'd16: return {1'b0, 16'h3500, 8'h00};
      8'd17: return {1'b0, 16'h3501, 8'h2a};
      8'd18: return {1'b0, 16'h3502, 8'h90};
      8'd19: return {1'b0, 16'h3503, 8'h08};
      8'd20: return {1'b0, 16'h3505, 8'h8c};
      8'd21: return {1'b0, 16'h3507, 8'h03};
      8'd22: return {1'b0, 16'h3508, 8'h00};
      8'd23: return {1'b0, 16'h3509, 8'h10};
      8'd24: return {1'b0, 16'h3610, 8'h80};
      8'd25: return {1'b0, 16'h3611, 8'ha0};
      8'd26: return {1'b0, 16'h3620, 8'h6e};
      8'd27: return {1'b0, 16'h3632, 8'h56};
      8'd28: return {1'b0, 16'h3633, 8'h78};
      8'd29: return {1'b0, 16'h3662, 8'h05};
      8'd30: return {1'b0, 16'h3666, 8'h00};
      8'd31: return {1'b0, 16'h366f, 8'h5a};
      8'd32: return {1'b0, 16'h3680, 8'h84};
      8'd33: return {1'b0, 16'h3712, 8'h80};
      8'd34: return {1'b0, 16'h372d, 8'h22};
      8'd35: return {1'b0, 16'h3731, 8'h80};
      8'd36: return {1'b0, 16'h3732, 8'h30};
      8'd37: return {1'b0, 16'h3778, 8'h00};
      8'd38: return {1'b0, 16'h377d, 8'h22};
      8'd39: return {1'b0, 16'h3788, 8'h02};
      8'd40: return {1'b0, 16'h3789, 8'ha4};
      8'd41: return {1'b0, 16'h378a, 8'h00};
      8'd42: return {1'b0, 16'h378b, 8'h4a};
      8'd43: return {1'b0, 16'h3799, 8'h20};
      8'd44: return {1'b0, 16'h3800, 8'h00};
      8'd45: return {1'b0, 16'h3801, 8'h00};
      8'd46: return {1'b0, 16'h3802, 8'h00};
      8'd47: return {1'b0, 16'h3803, 8'h00};
      8'd48: return {1'b0, 16'h3804, 8'h05};
      8'd49: return {1'b0, 16'h3805, 8'h0f};
      8'd50: return {1'b0, 16'h3806, 8'h03};
      8'd51: return {1'b0, 16'h3807, 8'h2f};
      8'd52: return {1'b0, 16'h3808, 8'h05};
      8'd53: return {1'b0, 16'h3809, 8'h00};
      8'd54: return {1'b0, 16'h380a, 8'h03};
      8'd55: return {1'b0, 16'h380b, 8'h20};
      8'd56: return {1'b0, 16'h380c, 8'h02};
      8'd57: return {1'b0, 16'h380d, 8'hd8};
      8'd58: return {1'b0, 16'h380e, 8'h03};
      8'd59: return {1'b0, 16'h380f, 8'h8e};
      8'd60: return {1'b0, 16'h3810, 8'h00};
      8'd61: return {1'b0, 16'h3811, 8'h08};
      8'd62: return {1'b0, 16'h3812, 8'h00};
      8'd63: return {1'b0, 16'h0100, 8'h01};
      // Out-of-range index reads as a zero-length delay so it can never hit the bus.
      default: return {1'b1, 16'h0000, 8'h00};
    endcase
  endfunction

  assign entry     = table_lookup(reg_index);
  assign delay_len = 16'(i2c_data[7:0]) * 16'(DELAY_UNIT);

  always_comb begin
    state_n = state;
    retry_n = retry;
    index_n = reg_index;
    data_n  = i2c_data;
    done_n  = cfg_done;
    err_n   = cfg_err;
    case (state)
      PWR_WAIT: if (cnt == 16'(PWR_DELAY - 1)) state_n = LOAD;
      LOAD: begin
        data_n  = {DEV_ADDR, entry[23:0]};
        state_n = entry[24] ? DELAY : SEND;
      end
      SEND: if (tr_end) state_n = CHECK;
      CHECK: begin
        if (!ack) begin
          retry_n = '0;
          state_n = ADV;
        end else if (retry < RW'(MAX_RETRY)) begin
          retry_n = retry + 1'b1;
          state_n = GAP;
        end else begin
          state_n = ERROR;
        end
      end
      GAP: if (cnt == 16'(GAP_CYCLES - 1)) state_n = LOAD;
      ADV: begin
        retry_n = '0;
        if (reg_index == 8'(REG_NUM - 1)) begin
          state_n = DONE;
        end else begin
          index_n = reg_index + 8'd1;
          state_n = GAP;
        end
      end
      DELAY: if ((cnt + 16'd1) >= delay_len) state_n = ADV;
      default: state_n = state;
    endcase
    if (state_n == DONE) done_n = 1'b1;
    if (state_n == ERROR) err_n = 1'b1;
    cnt_n = (state_n == state) ? cnt + 16'd1 : 16'd0;
    // Restart wins over everything, including an in-flight transfer.
    if (cfg_restart) begin
      state_n = GAP;
      cnt_n   = 16'd0;
      retry_n = '0;
      index_n = 8'd0;
      done_n  = 1'b0;
      err_n   = 1'b0;
    end
    start_n = (state_n == SEND) || (state_n == CHECK);
  end

  always_ff @(posedge clock_i2c or negedge camera_rstn) begin
    if (!camera_rstn) begin
      state     <= PWR_WAIT;
      cnt       <= 16'd0;
      retry     <= '0;
      reg_index <= 8'd0;
      i2c_data  <= 32'd0;
      start     <= 1'b0;
      cfg_done  <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      retry     <= retry_n;
      reg_index <= index_n;
      i2c_data  <= data_n;
      start     <= start_n;
      cfg_done  <= done_n;
      cfg_err   <= err_n;
    end
  end

endmodule

// File: tb/tb_i2c_reg_config.sv
// Directed bench for i2c_reg_config: a 42-cycle i2c_com engine model with a programmable
// NACKing slave, plus a monitor logging every start rise with its preceding low time.
module tb_i2c_reg_config;

  logic        clock_i2c = 1'b0;
  logic        camera_rstn = 1'b0;
  logic        cfg_restart = 1'b0;
  logic        tr_end;
  logic        ack;
  logic        start;
  logic [31:0] i2c_data;
  logic [7:0]  reg_index;
  logic        cfg_done;
  logic        cfg_err;

  int tests = 0;
  int failed = 0;

  i2c_reg_config dut (
    .clock_i2c   (clock_i2c),
    .camera_rstn (camera_rstn),
    .cfg_restart (cfg_restart),
    .tr_end      (tr_end),
    .ack         (ack),
    .start       (start),
    .i2c_data    (i2c_data),
    .reg_index   (reg_index),
    .cfg_done    (cfg_done),
    .cfg_err     (cfg_err)
  );

  always #5 clock_i2c = ~clock_i2c;

  // Slave policy: NACK nack_word for its first nack_limit sends, or always.
  logic [31:0] nack_word = 32'd0;
  int          nack_limit = 0;
  bit          nack_always = 1'b0;
  int          word_sends = 0;
  int          eng_cnt, low_cnt;

  always @(posedge clock_i2c or negedge camera_rstn) begin
    if (!camera_rstn) begin
      eng_cnt <= 0; low_cnt <= 0; tr_end <= 1'b0; ack <= 1'b0;
    end else if (start) begin
      low_cnt <= 0;
      if (eng_cnt < 41) eng_cnt <= eng_cnt + 1;
      if (eng_cnt == 40) begin
        tr_end <= 1'b1;
        ack <= (nack_word != 32'd0) && (i2c_data == nack_word) &&
               (nack_always || word_sends <= nack_limit);
      end
    end else begin
      eng_cnt <= 0;
      if (tr_end) begin
        if (low_cnt == 1) tr_end <= 1'b0;
        low_cnt <= low_cnt + 1;
      end else begin
        low_cnt <= 0;
      end
    end
  end

  logic [31:0] log_word [0:1023];
  int          log_gap  [0:1023];
  int          n_starts = 0;
  int          cyc = 0, first_cyc = 0, low_len = 0, viol = 0;
  bit          got_first = 1'b0, prev_start = 1'b0;

  always @(negedge clock_i2c) begin
    if (!camera_rstn) begin
      cyc = 0; got_first = 1'b0; low_len = 0; prev_start = 1'b0;
    end else begin
      cyc++;
      if (start && !prev_start) begin
        if (tr_end) viol++;
        if (n_starts < 1024) begin
          log_word[n_starts] = i2c_data;
          log_gap[n_starts]  = low_len;
        end
        n_starts++;
        if (!got_first) begin got_first = 1'b1; first_cyc = cyc; end
        if (i2c_data == nack_word) word_sends++;
      end
      low_len = start ? 0 : low_len + 1;
      prev_start = start;
    end
  end

  task automatic tick();
    @(negedge clock_i2c); #1;
  endtask

  task automatic pulse_restart();
    @(posedge clock_i2c); #1 cfg_restart = 1'b1;
    @(posedge clock_i2c); #1 cfg_restart = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge clock_i2c); #2 camera_rstn = 1'b1;
  endtask

  task automatic wait_end(input int budget, input string name);
    int n = 0;
    while (!(cfg_done || cfg_err) && n < budget) begin tick(); n++; end
    tests++;
    if (!(cfg_done || cfg_err)) begin
      failed++;
      $display("FAIL %s_timeout: no cfg_done/cfg_err after %0d cycles", name, budget);
    end
  endtask

  task automatic wait_first_start(input string name);
    int n = 0;
    while (!got_first && n < 5000) begin tick(); n++; end
    tests++;
    if (!got_first) begin failed++; $display("FAIL %s_timeout: start never rose", name); end
  endtask

  task automatic test_reset();
    camera_rstn = 1'b0;
    repeat (3) tick();
    tests++;
    if ({start, i2c_data, reg_index, cfg_done, cfg_err} !== 43'd0) begin
      failed++;
      $display("FAIL reset_outputs: got start=%0b data=%h idx=%0d done=%0b err=%0b want all 0",
               start, i2c_data, reg_index, cfg_done, cfg_err);
    end
  endtask

  task automatic test_powerup(output int base);
    base = n_starts;
    release_reset();
    wait_first_start("powerup");
    tests++;
    if (first_cyc != 4001) begin
      failed++; $display("FAIL powerup_latency: got %0d want 4001", first_cyc);
    end
    tests++;
    if (log_word[base] !== 32'hC0010301) begin
      failed++; $display("FAIL powerup_word: got %h want C0010301", log_word[base]);
    end
  endtask

  task automatic test_full_table(input int b);
    wait_end(10000, "full");
    tests++;
    if (cfg_done !== 1'b1 || cfg_err !== 1'b0) begin
      failed++; $display("FAIL full_flags: got done=%0b err=%0b want 1 0", cfg_done, cfg_err);
    end
    tests++;
    if (reg_index !== 8'd63 || start !== 1'b0) begin
      failed++; $display("FAIL full_idx_start: got idx=%0d start=%0b want 63 0", reg_index, start);
    end
    tests++;
    if (n_starts - b != 63) begin
      failed++; $display("FAIL full_count: got %0d writes want 63", n_starts - b);
    end
    tests++;
    if (log_word[b+1] !== 32'hC0030232 || log_word[b+9] !== 32'hC0301318 ||
        log_word[b+62] !== 32'hC0010001) begin
      failed++;
      $display("FAIL full_order: got %h %h %h want C0030232 C0301318 C0010001",
               log_word[b+1], log_word[b+9], log_word[b+62]);
    end
    tests++;
    if (log_gap[b+1] != 212) begin
      failed++; $display("FAIL delay_gap: got %0d low cycles want 212", log_gap[b+1]);
    end
    tests++;
    if (log_gap[b+2] != 6) begin
      failed++; $display("FAIL write_gap: got %0d low cycles want 6", log_gap[b+2]);
    end
    tests++;
    if (viol != 0) begin
      failed++; $display("FAIL start_during_tr_end: got %0d want 0", viol);
    end
  endtask

  task automatic test_nack_retry();
    int b;
    nack_word = 32'hC0300100; nack_limit = 2; nack_always = 1'b0; word_sends = 0;
    pulse_restart();
    tests++;
    if (cfg_done !== 1'b0 || reg_index !== 8'd0 || start !== 1'b0) begin
      failed++; $display("FAIL restart_in_done: got done=%0b idx=%0d start=%0b want 0 0 0",
                         cfg_done, reg_index, start);
    end
    b = n_starts;
    wait_end(5000, "retry");
    tests++;
    if (cfg_done !== 1'b1 || cfg_err !== 1'b0) begin
      failed++; $display("FAIL retry_flags: got done=%0b err=%0b want 1 0", cfg_done, cfg_err);
    end
    tests++;
    if (word_sends != 3 || n_starts - b != 65) begin
      failed++; $display("FAIL retry_count: got e5=%0d total=%0d want 3 65", word_sends, n_starts - b);
    end
    tests++;
    if (log_word[b+6] !== 32'hC0300100 || log_word[b+7] !== 32'hC0300400) begin
      failed++; $display("FAIL retry_order: got %h %h want C0300100 C0300400",
                         log_word[b+6], log_word[b+7]);
    end
    tests++;
    if (log_gap[b+5] != 5 || log_gap[b+6] != 5 || log_gap[b+7] != 6) begin
      failed++; $display("FAIL retry_gaps: got %0d %0d %0d want 5 5 6",
                         log_gap[b+5], log_gap[b+6], log_gap[b+7]);
    end
  endtask

  task automatic test_nack_error();
    int b, n;
    nack_word = 32'hC0300500; nack_always = 1'b1; word_sends = 0;
    pulse_restart();
    b = n_starts;
    wait_end(2000, "error");
    tests++;
    if (cfg_err !== 1'b1 || cfg_done !== 1'b0 || reg_index !== 8'd7) begin
      failed++; $display("FAIL error_state: got err=%0b done=%0b idx=%0d want 1 0 7",
                         cfg_err, cfg_done, reg_index);
    end
    tests++;
    if (word_sends != 4 || n_starts - b != 10) begin
      failed++; $display("FAIL error_count: got e7=%0d total=%0d want 4 10", word_sends, n_starts - b);
    end
    n = n_starts;
    repeat (300) tick();
    tests++;
    if (n_starts != n || start !== 1'b0 || cfg_err !== 1'b1) begin
      failed++; $display("FAIL error_hold: got new_starts=%0d start=%0b err=%0b want 0 0 1",
                         n_starts - n, start, cfg_err);
    end
    nack_word = 32'd0; nack_always = 1'b0;
    pulse_restart();
    tests++;
    if (cfg_err !== 1'b0 || reg_index !== 8'd0) begin
      failed++; $display("FAIL restart_in_error: got err=%0b idx=%0d want 0 0", cfg_err, reg_index);
    end
  endtask

  task automatic test_restart_mid_send();
    int b, b2, n;
    b = n_starts; n = 0;
    while (n_starts < b + 10 && n < 2000) begin tick(); n++; end
    repeat (10) tick();
    tests++;
    if (start !== 1'b1 || i2c_data !== 32'hC0301318) begin
      failed++; $display("FAIL mid_send_setup: got start=%0b data=%h want 1 C0301318", start, i2c_data);
    end
    pulse_restart();
    tests++;
    if (start !== 1'b0 || reg_index !== 8'd0) begin
      failed++; $display("FAIL restart_abort: got start=%0b idx=%0d want 0 0", start, reg_index);
    end
    b2 = n_starts;
    wait_end(5000, "restart");
    tests++;
    if (cfg_done !== 1'b1 || n_starts - b2 != 63 || log_word[b2] !== 32'hC0010301) begin
      failed++; $display("FAIL restart_rerun: got done=%0b writes=%0d first=%h want 1 63 C0010301",
                         cfg_done, n_starts - b2, log_word[b2]);
    end
    tests++;
    if (log_gap[b2] > 10) begin
      failed++; $display("FAIL restart_no_pwr_delay: got %0d low cycles want <=10", log_gap[b2]);
    end
    pulse_restart();
    tests++;
    if (cfg_done !== 1'b0) begin
      failed++; $display("FAIL restart_clears_done: got %0b want 0", cfg_done);
    end
  endtask

  task automatic test_reset_mid_transfer();
    int b, n;
    n = 0;
    while (start !== 1'b1 && n < 200) begin tick(); n++; end
    repeat (7) tick();
    #3 camera_rstn = 1'b0;
    #1;
    tests++;
    if ({start, i2c_data, reg_index, cfg_done, cfg_err} !== 43'd0) begin
      failed++;
      $display("FAIL async_reset: got start=%0b data=%h idx=%0d done=%0b err=%0b want all 0",
               start, i2c_data, reg_index, cfg_done, cfg_err);
    end
    repeat (2) tick();
    b = n_starts;
    release_reset();
    wait_first_start("reset_rerun");
    tests++;
    if (first_cyc != 4001 || log_word[b] !== 32'hC0010301) begin
      failed++; $display("FAIL reset_rerun: got latency=%0d word=%h want 4001 C0010301",
                         first_cyc, log_word[b]);
    end
  endtask

  initial begin
    int b;
    test_reset();
    test_powerup(b);
    test_full_table(b);
    test_nack_retry();
    test_nack_error();
    test_restart_mid_send();
    test_reset_mid_transfer();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
